morse_sequencer: RTL

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

---
 rtl/morse_pkg.sv | 43 ++++
 rtl/letter_fifo.sv | 70 +++++++
 rtl/morse_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Letter patterns, pattern width and FSM state encoding shared
//               by the Morse sequencer and its letter queue.
// Revision    : 1.0 - initial release
// ============================================================================
package morse_pkg;

    localparam int c_PATTERN_W = 12;

    localparam logic [c_PATTERN_W-1:0] c_PAT_A = 12'b1011_1000_0000;
    localparam logic [c_PATTERN_W-1:0] c_PAT_B = 12'b1110_1010_1000;
    localparam logic [c_PATTERN_W-1:0] c_PAT_C = 12'b1110_1011_1010;
    localparam logic [c_PATTERN_W-1:0] c_PAT_D = 12'b1110_1010_0000;
    localparam logic [c_PATTERN_W-1:0] c_PAT_E = 12'b1000_0000_0000;
    localparam logic [c_PATTERN_W-1:0] c_PAT_F = 12'b1010_1110_1000;
    localparam logic [c_PATTERN_W-1:0] c_PAT_G = 12'b1110_1110_1000;
    localparam logic [c_PATTERN_W-1:0] c_PAT_H = 12'b1010_1010_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [c_PATTERN_W-1:0] letter_pattern(input logic [2:0] letter);
        logic [c_PATTERN_W-1:0] pat;
        case (letter)
            3'd0:    pat = c_PAT_A;
            3'd1:    pat = c_PAT_B;
            3'd2:    pat = c_PAT_C;
            3'd3:    pat = c_PAT_D;
            3'd4:    pat = c_PAT_E;
            3'd5:    pat = c_PAT_F;
            3'd6:    pat = c_PAT_G;
            default: pat = c_PAT_H;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/letter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : letter_fifo
// Description : Small power-of-2 FIFO of 3-bit letter codes with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module letter_fifo
    import morse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [2:0]               i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [2:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count_next
);

    localparam int c_AW = $clog2(DEPTH);

    logic [2:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [c_AW:0]   w_count_next;

    // Exported so the parent can register its status flags from the same edge.
    always_comb begin
        w_count_next = r_count;
        if (i_flush)
            w_count_next = '0;
        else if (i_push && !i_pop)
            w_count_next = r_count + (c_AW+1)'(1);
        else if (!i_push && i_pop)
            w_count_next = r_count - (c_AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (i_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
                if (i_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data       = r_mem[r_rd_ptr];
    assign o_full       = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty      = (r_count == '0);
    assign o_count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morse_sequencer
// Description : Queues letters A..H and plays them as Morse dot/dash levels
//               with a fixed inter-letter gap.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int GAP_BITS        = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic [2:0] Letter,
    input  logic       LetterValid,
    output logic       LetterReady,
    input  logic       Abort,
    output logic       DotDashOut,
    output logic       NewBitOut,
    output logic       Busy
);

    localparam int c_TICK_CYCLES = CLOCK_FREQUENCY / 2;
    localparam int c_TICK_W      = (c_TICK_CYCLES > 1) ? $clog2(c_TICK_CYCLES) : 1;
    localparam int c_CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_TICK_W-1:0] c_TICK_RELOAD = c_TICK_W'(c_TICK_CYCLES - 1);
    localparam logic [2:0]          c_GAP_RELOAD  = 3'(GAP_BITS - 1);

    state_t                 r_state;
    logic [c_PATTERN_W-1:0] r_shift;
    logic [c_TICK_W-1:0]    r_tick;
    logic [2:0]             r_gap;
    logic                   r_dot;
    logic                   r_new;
    logic                   r_busy;
    logic                   r_ready;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [2:0]             w_head;
    logic [c_CNT_W-1:0]     w_count_next;
    logic [c_PATTERN_W-1:0] w_head_pat;
    logic [c_PATTERN_W-1:0] w_shifted;
    logic                   w_tick_done;
    logic                   w_next_idle;

    assign w_push      = LetterValid & ~w_full & ~Abort;
    assign w_pop       = (r_state == ST_IDLE) & ~w_empty & ~Abort;
    assign w_head_pat  = letter_pattern(w_head);
    assign w_shifted   = {r_shift[c_PATTERN_W-2:0], 1'b0};
    assign w_tick_done = (r_tick == '0);
    assign w_next_idle = Abort
                       | ((r_state == ST_IDLE) & ~w_pop)
                       | ((r_state == ST_GAP) & w_tick_done & (r_gap == 3'd0));

    letter_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_letter_fifo (
        .clk          (ClockIn),
        .rst_n        (Resetn),
        .i_push       (w_push),
        .i_data       (Letter),
        .i_pop        (w_pop),
        .i_flush      (Abort),
        .o_data       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count_next (w_count_next)
    );

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_tick  <= '0;
            r_gap   <= '0;
            r_dot   <= 1'b0;
            r_new   <= 1'b0;
        end else begin
            r_new <= 1'b0;
            if (Abort) begin
                r_state <= ST_IDLE;
                r_shift <= '0;
                r_tick  <= '0;
                r_gap   <= '0;
                r_dot   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_shift <= w_head_pat;
                            r_dot   <= w_head_pat[c_PATTERN_W-1];
                            r_new   <= 1'b1;
                            r_tick  <= c_TICK_RELOAD;
                            r_state <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (w_tick_done) begin
                            r_shift <= w_shifted;
                            r_tick  <= c_TICK_RELOAD;
                            r_new   <= 1'b1;
                            // An empty shift register means the last mark has been played.
                            if (w_shifted != '0) begin
                                r_dot <= w_shifted[c_PATTERN_W-1];
                            end else begin
                                r_dot   <= 1'b0;
                                r_gap   <= c_GAP_RELOAD;
                                r_state <= ST_GAP;
                            end
                        end else begin
                            r_tick <= r_tick - c_TICK_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (w_tick_done) begin
                            if (r_gap == 3'd0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_gap  <= r_gap - 3'd1;
                                r_tick <= c_TICK_RELOAD;
                                r_new  <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick - c_TICK_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_busy  <= ~w_next_idle | (w_count_next != '0);
            r_ready <= (w_count_next != c_CNT_W'(FIFO_DEPTH));
        end
    end

    assign DotDashOut  = r_dot;
    assign NewBitOut   = r_new;
    assign Busy        = r_busy;
    assign LetterReady = r_ready;

endmodule
`default_nettype wire
